// File: rtl/period_meter_pkg.sv
// Shared definitions for the period meter: state encodings and the width helper
// that is also used when sizing the team's clock dividers.
package period_meter_pkg;

  localparam logic [1:0] EncIdle    = 2'd0;
  localparam logic [1:0] EncArm     = 2'd1;
  localparam logic [1:0] EncMeasure = 2'd2;
  localparam logic [1:0] EncHold    = 2'd3;

  typedef enum logic [1:0] {
    StIdle    = EncIdle,
    StArm     = EncArm,
    StMeasure = EncMeasure,
    StHold    = EncHold
  } pm_state_e;

  // Smallest width w such that 2**w >= value.
  function automatic int unsigned ceillog2(input longint unsigned value);
    int unsigned      width;
    longint unsigned  span;
    width = 0;
    span  = 1;
    while (span < value) begin
      span  = span << 1;
      width = width + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous level, plus single-cycle rise/fall
// pulses derived from the synchronized value.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d_async,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= d_async;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level = sync_q;
  assign rise  = sync_q & ~prev_q;
  assign fall  = ~sync_q & prev_q;

endmodule

// File: rtl/period_meter.sv
// Measures period and high time of a slow input in system clock cycles,
// reporting each rise-to-rise interval through a valid/ready handshake.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int unsigned MAX_COUNT = 50000000,
  localparam int unsigned CNT_W = ceillog2(MAX_COUNT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             sig_in,
  input  logic             ready,
  output logic             valid,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(MAX_COUNT);
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic sig_rise, sig_fall, sig_level_unused;

  sync_edge u_sync_edge (
    .clk     (clk),
    .rst     (rst),
    .d_async (sig_in),
    .level   (sig_level_unused),
    .rise    (sig_rise),
    .fall    (sig_fall)
  );

  pm_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] h_lat_q, h_lat_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_time_q, high_time_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    h_lat_d     = h_lat_q;
    period_d    = period_q;
    high_time_d = high_time_q;
    valid_d     = valid_q;
    timeout_d   = 1'b0;
    // Disable wins over everything; the last result stays on the outputs.
    if (!enable) begin
      state_d = StIdle;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: state_d = StArm;
        StArm: begin
          if (sig_rise) begin
            cnt_d   = CntOne;
            h_lat_d = '0;
            state_d = StMeasure;
          end
        end
        StMeasure: begin
          // A rise on the last allowed count is still a valid result.
          if (sig_rise) begin
            period_d    = cnt_q;
            high_time_d = h_lat_q;
            valid_d     = 1'b1;
            cnt_d       = CntOne;
            state_d     = StHold;
          end else if (cnt_q == CntMax) begin
            timeout_d = 1'b1;
            state_d   = StArm;
          end else begin
            cnt_d = cnt_q + CntOne;
            if (sig_fall) begin
              h_lat_d = cnt_q;
            end
          end
        end
        StHold: begin
          if (ready) begin
            valid_d = 1'b0;
            state_d = StArm;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      h_lat_q     <= '0;
      period_q    <= '0;
      high_time_q <= '0;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      h_lat_q     <= h_lat_d;
      period_q    <= period_d;
      high_time_q <= high_time_d;
      valid_q     <= valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign valid     = valid_q;
  assign period    = period_q;
  assign high_time = high_time_q;
  assign timeout   = timeout_q;

endmodule

// File: doc/period_meter.md
Name: period_meter

Overview:
- Measures a slow incoming clock or square wave (`sig_in`) in units of the system clock.
- It is the receiving end of the divided clocks the team generates: a divider turns a count N into a waveform, and this block turns the waveform back into cycle counts.
- Reports period and high-time per rising-to-rising interval through a valid/ready handshake, with timeout detection for a stalled or absent input.
- Used for self-check of divider outputs and for measuring external slow signals.

Parameters:
- MAX_COUNT, 50000000, largest period (in clk cycles) accepted before timeout; must be ≥ 4.
- CNT_W (localparam), ceillog2(MAX_COUNT+1), width of the counter and of the result ports.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-low reset; asserts immediately, deasserts synchronously via standard release.
- enable  in  1  measurement enable; low aborts any measurement and returns to IDLE.
- sig_in  in  1  asynchronous input waveform being measured.
- ready  in  1  consumer accepts the result when high together with valid.
- valid  out  1  result available; reset 0.
- period  out  CNT_W  clk cycles between consecutive detected rising edges; reset 0.
- high_time  out  CNT_W  clk cycles from detected rise to detected fall within that period; reset 0.
- timeout  out  1  one-cycle pulse when no rising edge arrives within MAX_COUNT cycles; reset 0.

Behaviour:
- Input conditioning:
  - 2-FF synchronizer on `sig_in`, both flops reset to 0.
  - Edge detector compares the synchronized value with its previous value, giving `rise` and `fall` pulses.
  - A `sig_in` transition appears as a `rise`/`fall` pulse in the 3rd clk after it becomes stable.
- Counter `cnt` (CNT_W bits):
  - On `rise`, cnt <= 1.
  - Otherwise it increments by 1 each cycle in MEASURE.
  - It never wraps; the timeout check prevents overflow.
- FSM states: IDLE, ARM, MEASURE, HOLD. Reset state is IDLE.
  - IDLE: when enable=1, go to ARM next cycle.
  - ARM: wait for `rise`. On `rise`, cnt <= 1, h_lat <= 0, go to MEASURE. There is no timeout in ARM.
  - MEASURE:
    - On `fall`, h_lat <= cnt.
    - On `rise`: period <= cnt, high_time <= h_lat, valid <= 1, go to HOLD.
    - When cnt == MAX_COUNT and no `rise`: timeout pulses for 1 cycle, go to ARM, no result.
    - A `rise` coincident with cnt == MAX_COUNT is a valid result (period = MAX_COUNT); no timeout.
  - HOLD:
    - valid stays 1 and period/high_time stay stable.
    - `sig_in` edges are ignored.
    - On valid&&ready, valid <= 0 next cycle and go to ARM.
    - The next measurement starts at the next fresh `rise`, so intervals overlapping HOLD are skipped.
- Ready may be high before valid. Acceptance then occurs on the first cycle valid=1, and valid is high for exactly 1 cycle.
- A `fall` before any `rise` in MEASURE is impossible by construction. If no `fall` occurs in an interval, high_time = 0.
- enable=0 in any state:
  - Go to IDLE next cycle and clear valid (a pending result is discarded).
  - timeout does not pulse.
  - period/high_time hold their last values.
- Reset mid-operation: all outputs and state return to their reset values immediately.
- Minimum measurable input: high and low phases each ≥ 2 clk cycles. Shorter pulses may be missed; this is not checked.

Decomposition:
- Shared package/include holds:
  - the ceillog2 constant function, used with the team's dividers;
  - FSM state encodings IDLE/ARM/MEASURE/HOLD as localparams.
- One natural sub-module: `sync_edge`, the 2-FF synchronizer plus rise/fall pulse generator (ports clk, rst, d_async, level, rise, fall). It is reused elsewhere for buttons and external strobes.

Test Plan:
- Reset and idle: rst=0 mid-run, then release with enable=0 and sig_in toggling -> valid=0, timeout=0, period=0, high_time=0; no state change.
- Divider loopback: `sig_in` driven by the team clock divider with N=4 (toggle every 4 clk), enable=1, ready=1 -> each result period=8, high_time=4. With ready always high, valid pulses every other interval (HOLD skips one interval).
- Asymmetric wave: high 3 / low 7 cycles, ready held low for 30 cycles then high -> period=10, high_time=3. Values stay stable through the wait and valid stays high until accept; edges during the wait are ignored.
- Timeout: MAX_COUNT=16, one rise then sig_in held low -> timeout pulses exactly once, at the 16th counting cycle after the rise. No valid; the FSM re-arms, and a later wave with period 12 gives period=12.
- Boundary: MAX_COUNT=16, period exactly 16 -> valid with period=16, no timeout. Period 17 -> timeout, no result.
- Abort: enable dropped while valid=1 and ready=0 -> valid=0 next cycle. After re-enable, the first result needs two fresh rising edges.
